// File: rtl/mil_word_receiver.sv
// Manchester-II word receiver: recovers sync type, 16 data bits and odd parity
// from a differential line pair and pushes each good word to a request/done consumer.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  S_IDLE    | line idle, waiting for the first non-idle level
//  S_DECODE  | sampling sync and bit halves against the word timer
//  S_WAIT    | word rejected, waiting for the line to return to idle
module mil_word_receiver #(
    parameter int BIT_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_p,
    input  logic        line_n,
    output logic        out_request,
    output logic [15:0] out_data,
    output logic        out_is_cmd,
    input  logic        out_done,
    output logic        err_sync,
    output logic        err_manchester,
    output logic        err_parity,
    output logic        err_overflow,
    output logic        rx_busy
);

    localparam int H  = BIT_CYCLES / 2;
    localparam int PW = $clog2(2 * H + 1);

    // The word timer is split into a phase within a 2H window and a window index.
    // Sync and bit boundaries all fall on 2H multiples, so every sample point is a
    // fixed phase in a known window and no divider is needed.
    localparam logic [PW-1:0] PH_Q1    = PW'(H / 2);
    localparam logic [PW-1:0] PH_Q3    = PW'(3 * H / 2);
    localparam logic [PW-1:0] PH_END   = PW'(2 * H - 1);
    localparam logic [4:0]    BW_SYNC2 = 5'd2;
    localparam logic [4:0]    BW_BIT0  = 5'd3;
    localparam logic [4:0]    BW_LAST  = 5'd19;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [4:0]    bw_q, bw_d;
    logic          sync1_act_q, sync1_act_d, sync1_hi_q, sync1_hi_d;
    logic          half_act_q, half_act_d, half_hi_q, half_hi_d;
    logic [16:0]   sh_q, sh_d;
    logic          word_cmd_q, word_cmd_d;
    logic          out_request_q, out_request_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          out_is_cmd_q, out_is_cmd_d;
    logic          err_sync_q, err_sync_d;
    logic          err_man_q, err_man_d;
    logic          err_par_q, err_par_d;
    logic          err_ovf_q, err_ovf_d;

    logic p_meta_q, p_sync_q, n_meta_q, n_sync_q;
    logic lvl_hi, lvl_lo, lvl_act;
    logic bit_win, last, man_fail;

    // Two-flop synchronisers for both line legs.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_meta_q <= 1'b0;
            p_sync_q <= 1'b0;
            n_meta_q <= 1'b0;
            n_sync_q <= 1'b0;
        end else begin
            p_meta_q <= line_p;
            p_sync_q <= p_meta_q;
            n_meta_q <= line_n;
            n_sync_q <= n_meta_q;
        end
    end

    assign lvl_hi  = p_sync_q & ~n_sync_q;
    assign lvl_lo  = ~p_sync_q & n_sync_q;
    assign lvl_act = lvl_hi | lvl_lo;
    assign bit_win = (bw_q >= BW_BIT0);
    assign last    = (bw_q == BW_LAST) && (ph_q == PH_END);

    // Next-state: timer, sampling, word checks and consumer handshake.
    always_comb begin
        state_d       = state_q;
        ph_d          = ph_q;
        bw_d          = bw_q;
        sync1_act_d   = sync1_act_q;
        sync1_hi_d    = sync1_hi_q;
        half_act_d    = half_act_q;
        half_hi_d     = half_hi_q;
        sh_d          = sh_q;
        word_cmd_d    = word_cmd_q;
        out_request_d = out_request_q & ~out_done;
        out_data_d    = out_data_q;
        out_is_cmd_d  = out_is_cmd_q;
        err_sync_d    = 1'b0;
        err_man_d     = 1'b0;
        err_par_d     = 1'b0;
        err_ovf_d     = 1'b0;
        man_fail      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // The first active cycle is t=0, so the timer enters DECODE at t=1.
                if (lvl_act) begin
                    state_d = S_DECODE;
                    ph_d    = PW'(1);
                    bw_d    = 5'd0;
                end
            end
            S_DECODE: begin
                if (ph_q == PH_END) begin
                    ph_d = '0;
                    bw_d = bw_q + 5'd1;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
                // A restart after a word lands here at t=0; an idle line means no follow-on word.
                if (bw_q == 5'd0 && ph_q == '0 && !lvl_act) begin
                    state_d = S_IDLE;
                end
                if (bw_q == 5'd0 && ph_q == PH_Q3) begin
                    sync1_act_d = lvl_act;
                    sync1_hi_d  = lvl_hi;
                end
                if (bw_q == BW_SYNC2 && ph_q == PH_Q1) begin
                    if (!sync1_act_q || !lvl_act || (sync1_hi_q == lvl_hi)) begin
                        err_sync_d = 1'b1;
                        state_d    = S_WAIT;
                    end else begin
                        word_cmd_d = sync1_hi_q;
                    end
                end
                if (bit_win && ph_q == PH_Q1) begin
                    half_act_d = lvl_act;
                    half_hi_d  = lvl_hi;
                    sh_d       = {sh_q[15:0], lvl_hi};
                end
                if (bit_win && ph_q == PH_Q3) begin
                    if (!half_act_q || !lvl_act || (half_hi_q == lvl_hi)) begin
                        man_fail  = 1'b1;
                        err_man_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end
                // The parity bit's second half may be sampled in this same cycle.
                if (last && !man_fail) begin
                    if (!(^sh_q)) begin
                        err_par_d = 1'b1;
                        state_d   = S_WAIT;
                    end else begin
                        if (out_request_q && !out_done) begin
                            err_ovf_d = 1'b1;
                        end else begin
                            out_request_d = 1'b1;
                            out_data_d    = sh_q[16:1];
                            out_is_cmd_d  = word_cmd_q;
                        end
                        if (lvl_act) begin
                            ph_d = '0;
                            bw_d = 5'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!lvl_act) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ph_q          <= '0;
            bw_q          <= '0;
            sync1_act_q   <= 1'b0;
            sync1_hi_q    <= 1'b0;
            half_act_q    <= 1'b0;
            half_hi_q     <= 1'b0;
            sh_q          <= '0;
            word_cmd_q    <= 1'b0;
            out_request_q <= 1'b0;
            out_data_q    <= '0;
            out_is_cmd_q  <= 1'b0;
            err_sync_q    <= 1'b0;
            err_man_q     <= 1'b0;
            err_par_q     <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            bw_q          <= bw_d;
            sync1_act_q   <= sync1_act_d;
            sync1_hi_q    <= sync1_hi_d;
            half_act_q    <= half_act_d;
            half_hi_q     <= half_hi_d;
            sh_q          <= sh_d;
            word_cmd_q    <= word_cmd_d;
            out_request_q <= out_request_d;
            out_data_q    <= out_data_d;
            out_is_cmd_q  <= out_is_cmd_d;
            err_sync_q    <= err_sync_d;
            err_man_q     <= err_man_d;
            err_par_q     <= err_par_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    assign out_request    = out_request_q;
    assign out_data       = out_data_q;
    assign out_is_cmd     = out_is_cmd_q;
    assign err_sync       = err_sync_q;
    assign err_manchester = err_man_q;
    assign err_parity     = err_par_q;
    assign err_overflow   = err_ovf_q;
    assign rx_busy        = (state_q == S_DECODE);

endmodule

// File: tb/tb_mil_word_receiver.sv
// Directed bench for mil_word_receiver at BIT_CYCLES=4 (H=2, 80-cycle words).
module tb_mil_word_receiver;

    localparam int BC = 4;
    localparam int H  = BC / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_p, line_n;
    logic        out_request;
    logic [15:0] out_data;
    logic        out_is_cmd;
    logic        out_done;
    logic        err_sync, err_manchester, err_parity, err_overflow;
    logic        rx_busy;

    mil_word_receiver #(.BIT_CYCLES(BC)) dut (
        .clk            (clk),
        .rst            (rst),
        .line_p         (line_p),
        .line_n         (line_n),
        .out_request    (out_request),
        .out_data       (out_data),
        .out_is_cmd     (out_is_cmd),
        .out_done       (out_done),
        .err_sync       (err_sync),
        .err_manchester (err_manchester),
        .err_parity     (err_parity),
        .err_overflow   (err_overflow),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: request rising edges and error pulse counts/cycles.
    int          req_cyc[$];
    logic [15:0] req_dat[$];
    logic        req_cmd[$];
    logic        req_prev, busy_prev, em_drop;
    logic [15:0] dat_prev;
    int n_es = 0, n_em = 0, n_ep = 0, n_eo = 0, n_unstable = 0;
    int c_es = 0, c_em = 0, c_ep = 0, c_eo = 0;

    always @(negedge clk) begin
        req_prev  <= out_request;
        busy_prev <= rx_busy;
        dat_prev  <= out_data;
        if (out_request && !req_prev) begin
            req_cyc.push_back(cyc);
            req_dat.push_back(out_data);
            req_cmd.push_back(out_is_cmd);
        end
        if (out_request && req_prev && (out_data != dat_prev)) n_unstable <= n_unstable + 1;
        if (err_sync)       begin n_es <= n_es + 1; c_es <= cyc; end
        if (err_manchester) begin n_em <= n_em + 1; c_em <= cyc; em_drop <= busy_prev && !rx_busy; end
        if (err_parity)     begin n_ep <= n_ep + 1; c_ep <= cyc; end
        if (err_overflow)   begin n_eo <= n_eo + 1; c_eo <= cyc; end
    end

    // Consumer: acks 3 cycles after request rises, or on demand from the main sequence.
    int ack_req = 0, ack_served = 0, age = 0;
    bit auto_ack = 1'b1;
    initial begin
        out_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_done = 1'b0;
            age = out_request ? age + 1 : 0;
            if (ack_req != ack_served) begin
                out_done = 1'b1;
                ack_served = ack_served + 1;
            end else if (auto_ack && age == 3) begin
                out_done = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int checks = 0, errors = 0;
    int s_es, s_em, s_ep, s_eo, s_un;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_es = n_es; s_em = n_em; s_ep = n_ep; s_eo = n_eo; s_un = n_unstable;
    endtask

    // Called and returns at #1 after a rising edge; holds the line pair for n cycles.
    task automatic hold(input logic p, input logic n, input int cycles);
        line_p = p;
        line_n = n;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input bit cmd, input logic [15:0] d, input bit flip_par,
                             input int man_bit, input bit bad_sync, output int start);
        logic par, b;
        start = cyc;
        par = ~(^d) ^ flip_par;
        hold(cmd, ~cmd, 3 * H);
        if (bad_sync) hold(cmd, ~cmd, 3 * H);
        else          hold(~cmd, cmd, 3 * H);
        for (int i = 0; i < 17; i++) begin
            b = (i < 16) ? d[15 - i] : par;
            hold(b, ~b, H);
            if (i == man_bit) hold(b, ~b, H);
            else              hold(~b, b, H);
        end
    endtask

    initial begin
        int s, s2, nr;
        rst = 1'b1;
        line_p = 1'b0;
        line_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_request", 32'(out_request), 32'd0);
        chk("reset_data",    32'(out_data),    32'd0);
        chk("reset_is_cmd",  32'(out_is_cmd),  32'd0);
        chk("reset_errs",    32'({err_sync, err_manchester, err_parity, err_overflow}), 32'd0);
        chk("reset_busy",    32'(rx_busy),     32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b0, 1'b0, 4);

        // 1: command word A5C3
        snap(); nr = req_cyc.size();
        send_word(1'b1, 16'hA5C3, 1'b0, -1, 1'b0, s);
        hold(1'b0, 1'b0, 12);
        chk("t1_push_count", 32'(req_cyc.size() - nr), 32'd1);
        if (req_cyc.size() > nr) begin
            chk("t1_latency", 32'(req_cyc[nr] - s), 32'd82);
            chk("t1_data",    32'(req_dat[nr]),     32'h0000A5C3);
            chk("t1_is_cmd",  32'(req_cmd[nr]),     32'd1);
        end
        chk("t1_no_errors", 32'((n_es - s_es) + (n_em - s_em) + (n_ep - s_ep) + (n_eo - s_eo)), 32'd0);

        // 2: contiguous data words 0000 then FFFF
        snap(); nr = req_cyc.size();
        send_word(1'b0, 16'h0000, 1'b0, -1, 1'b0, s);
        send_word(1'b0, 16'hFFFF, 1'b0, -1, 1'b0, s2);
        hold(1'b0, 1'b0, 12);
        chk("t2_push_count", 32'(req_cyc.size() - nr), 32'd2);
        if (req_cyc.size() > nr + 1) begin
            chk("t2_latency",  32'(req_cyc[nr] - s),              32'd82);
            chk("t2_spacing",  32'(req_cyc[nr + 1] - req_cyc[nr]), 32'd80);
            chk("t2_data0",    32'(req_dat[nr]),                   32'h00000000);
            chk("t2_data1",    32'(req_dat[nr + 1]),               32'h0000FFFF);
            chk("t2_is_cmd",   32'({req_cmd[nr], req_cmd[nr + 1]}), 32'd0);
        end
        chk("t2_no_errors", 32'((n_es - s_es) + (n_em - s_em) + (n_ep - s_ep) + (n_eo - s_eo)), 32'd0);

        // 3: parity error on 1234, then a good data word 00F1
        snap(); nr = req_cyc.size();
        send_word(1'b1, 16'h1234, 1'b1, -1, 1'b0, s);
        hold(1'b0, 1'b0, 10);
        chk("t3_parity_pulses", 32'(n_ep - s_ep), 32'd1);
        chk("t3_parity_cycle",  32'(c_ep - s),    32'd82);
        chk("t3_no_push",       32'(req_cyc.size() - nr), 32'd0);
        send_word(1'b0, 16'h00F1, 1'b0, -1, 1'b0, s);
        hold(1'b0, 1'b0, 12);
        chk("t3_push_after", 32'(req_cyc.size() - nr), 32'd1);
        if (req_cyc.size() > nr) begin
            chk("t3_latency", 32'(req_cyc[nr] - s), 32'd82);
            chk("t3_data",    32'(req_dat[nr]),     32'h000000F1);
            chk("t3_is_cmd",  32'(req_cmd[nr]),     32'd0);
        end

        // 4a: bit 5 second half equal to first half
        snap(); nr = req_cyc.size();
        send_word(1'b1, 16'hC0DE, 1'b0, 5, 1'b0, s);
        hold(1'b0, 1'b0, 8);
        chk("t4_man_pulses", 32'(n_em - s_em), 32'd1);
        chk("t4_man_cycle",  32'(c_em - s),    32'd38);
        chk("t4_busy_drop",  32'(em_drop),     32'd1);
        chk("t4_man_no_par", 32'(n_ep - s_ep), 32'd0);

        // 4b: sync held high for 6H
        snap();
        send_word(1'b1, 16'h3C3C, 1'b0, -1, 1'b1, s);
        hold(1'b0, 1'b0, 8);
        chk("t4_sync_pulses", 32'(n_es - s_es), 32'd1);
        chk("t4_sync_cycle",  32'(c_es - s),    32'd12);
        chk("t4_sync_others", 32'((n_em - s_em) + (n_ep - s_ep)), 32'd0);
        chk("t4_no_push",     32'(req_cyc.size() - nr), 32'd0);

        // 5: done withheld over two words
        auto_ack = 1'b0;
        snap(); nr = req_cyc.size();
        send_word(1'b1, 16'h0F0F, 1'b0, -1, 1'b0, s);
        send_word(1'b0, 16'h00FF, 1'b0, -1, 1'b0, s2);
        hold(1'b0, 1'b0, 10);
        chk("t5_push_count",  32'(req_cyc.size() - nr), 32'd1);
        chk("t5_ovf_pulses",  32'(n_eo - s_eo),         32'd1);
        chk("t5_ovf_cycle",   32'(c_eo - s2),           32'd82);
        chk("t5_held_data",   32'(out_data),            32'h00000F0F);
        chk("t5_held_cmd",    32'(out_is_cmd),          32'd1);
        chk("t5_held_req",    32'(out_request),         32'd1);
        chk("t5_data_stable", 32'(n_unstable - s_un),   32'd0);
        ack_req = ack_req + 1;
        for (int k = 0; k < 10 && !out_done; k++) @(negedge clk);
        chk("t5_done_seen",   32'(out_done),    32'd1);
        chk("t5_req_at_done", 32'(out_request), 32'd1);
        @(negedge clk);
        chk("t5_req_dropped", 32'(out_request), 32'd0);
        auto_ack = 1'b1;
        hold(1'b0, 1'b0, 4);

        // 6: reset at t=30 mid-word, then a clean command word 8001
        snap(); nr = req_cyc.size();
        hold(1'b1, 1'b0, 3 * H);
        hold(1'b0, 1'b1, 3 * H);
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 1'b0, H);
            hold(1'b0, 1'b1, H);
        end
        chk("t6_busy_before", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        hold(1'b0, 1'b0, 2);
        rst = 1'b0;
        chk("t6_rst_request", 32'(out_request), 32'd0);
        chk("t6_rst_data",    32'(out_data),    32'd0);
        chk("t6_rst_is_cmd",  32'(out_is_cmd),  32'd0);
        chk("t6_rst_busy",    32'(rx_busy),     32'd0);
        hold(1'b0, 1'b0, 6);
        chk("t6_no_errors", 32'((n_es - s_es) + (n_em - s_em) + (n_ep - s_ep) + (n_eo - s_eo)), 32'd0);
        send_word(1'b1, 16'h8001, 1'b0, -1, 1'b0, s);
        hold(1'b0, 1'b0, 12);
        chk("t6_push_count", 32'(req_cyc.size() - nr), 32'd1);
        if (req_cyc.size() > nr) begin
            chk("t6_latency", 32'(req_cyc[nr] - s), 32'd82);
            chk("t6_data",    32'(req_dat[nr]),     32'h00008001);
            chk("t6_is_cmd",  32'(req_cmd[nr]),     32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
